pc_next_unit: RTL and testbench
===============================

# pc_next_unit

Parametrised program-counter unit for the RISC-V core. It holds the PC register and issues fetch requests to instruction memory with a valid/ready handshake. It resolves the next PC from sequential advance, conditional branches (all six RV32I/RV64I conditions), JAL and JALR, and enters a trap state on a misaligned control-transfer target. It sits between the decode/execute flag outputs and instruction memory.

## Interface
- ADDR_W, 8, PC/address width in bits (4..64)
- RESET_PC, 0, PC value loaded by reset
- TRAP_PC, 8'h80, PC value loaded when a trap is cleared
- clk  in  1  core clock
- rst_n  in  1  reset; asynchronous, active-low
- stall  in  1  hazard stall; blocks PC advance
- fetch_ready  in  1  instruction memory accepts the current PC
- fetch_valid  out  1  PC is a valid fetch request
- pc  out  ADDR_W  current PC
- pc_plus4  out  ADDR_W  pc + 4 mod 2^ADDR_W (link value, combinational)
- branch  in  1  current instruction is a conditional branch
- br_funct3  in  3  branch condition code
- zero, lt, ltu  in  1 each  ALU flags: rs1==rs2, signed rs1<rs2, unsigned rs1<rs2
- jal, jalr  in  1 each  current instruction is JAL / JALR
- imm  in  64  immediate from the immediate generator
- rs1_val  in  64  rs1 operand for JALR
- trap_clear  in  1  leave the trap state
- redirect  out  1  registered; high for one cycle after a taken transfer updated the PC
- misaligned  out  1  high while in TRAP

## Operation
- States: BOOT, RUN, TRAP.
- Reset values: state=BOOT, pc=RESET_PC, fetch_valid=0, redirect=0, misaligned=0.
- BOOT: lasts one cycle with fetch_valid=0, then goes to RUN.
- RUN: fetch_valid=1. advance = fetch_ready & ~stall. Control inputs are meaningful only on advance cycles and are ignored otherwise.
- Branch target and JAL target: pc + (imm << 1). JALR target: (rs1_val + imm) with bit 0 cleared. All sums are computed at 64 bits and truncated to ADDR_W, so they wrap modulo 2^ADDR_W.
- Taken conditions by br_funct3:
  - 000 BEQ: zero
  - 001 BNE: ~zero
  - 100 BLT: lt
  - 101 BGE: ~lt
  - 110 BLTU: ltu
  - 111 BGEU: ~ltu
  - Other codes: not taken.
- Priority when several control inputs are high: jalr > jal > branch.
- Taken transfer whose target[1:0] != 0:
  - pc is held.
  - state goes to TRAP and redirect stays 0.
- Taken transfer with an aligned target: pc loads the target and redirect=1 for the next cycle.
- Not taken: pc loads pc_plus4.
- TRAP: fetch_valid=0 and misaligned=1. On trap_clear, pc loads TRAP_PC and state goes to RUN. stall and fetch_ready are ignored in TRAP.
- trap_clear outside TRAP has no effect.

## Timing
- One-cycle latency: the PC update is visible on the clock edge after the advance cycle.
- fetch_valid is low for exactly 1 cycle after reset deassertion.
- Handshake:
  - While fetch_valid=1 and fetch_ready=0, pc is stable.
  - fetch_valid is not dropped in RUN without a trap.
- Asynchronous reset returns all state to reset values immediately in any state, including TRAP.
- Simultaneous stall=1 and fetch_ready=1: no advance.
- The taken decision and target are combinational from registered pc plus inputs. There is no combinational path from fetch_ready to pc.

## Structure
- pc_pkg holds:
  - the state enum (BOOT/RUN/TRAP)
  - br_funct3 constants BEQ, BNE, BLT, BGE, BLTU, BGEU
  - the JALR LSB mask.
- Sub-module pc_target_gen is combinational. It computes pc_plus4, the branch/JAL/JALR targets, taken, and the misalignment flag for a given ADDR_W.
- The top level holds the FSM, the PC register and the redirect register.

## Test plan
All scenarios use ADDR_W=8, RESET_PC=0x00, TRAP_PC=0x80.
- Reset then fetch_ready=1, no control inputs -> fetch_valid=0 for 1 cycle, then pc = 0x00, 0x04, 0x08, 0x0C on successive cycles.
- pc=0x10, branch=1, br_funct3=000, imm=6:
  - zero=1 -> pc=0x1C and redirect pulses once.
  - zero=0 -> pc=0x14 and redirect=0.
- Wrap-around:
  - pc=0xFC, no branch -> pc=0x00.
  - pc=0x04, BNE taken, imm=-2 -> pc=0x00.
  - pc=0x00, jal, imm=-2 -> pc=0xFC.
- JALR:
  - rs1_val=0x41, imm=3 -> pc=0x44.
  - rs1_val=0x40, imm=2 -> pc held, misaligned=1, fetch_valid=0.
  - Then trap_clear=1 -> pc=0x80, misaligned=0.
- Backpressure:
  - fetch_ready=0 for 3 cycles with jal=1 -> pc unchanged.
  - stall=1 with fetch_ready=1 -> pc unchanged.
  - Release -> single advance.
- rst_n pulsed low mid-cycle while in TRAP -> pc=0x00, misaligned=0, fetch_valid=0 immediately, then BOOT.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter unit: FSM states,
// branch condition codes and the mask that clears bit 0 of a JALR target.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } state_t;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  localparam logic [63:0] JALR_LSB_MASK = ~64'd1;

endpackage

// File: rtl/pc_target_gen.sv
// Combinational next-PC candidates: link value, selected transfer target,
// taken decision and misalignment of that target.
module pc_target_gen
  import pc_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              branch,
  input  logic [2:0]        br_funct3,
  input  logic              zero,
  input  logic              lt,
  input  logic              ltu,
  input  logic              jal,
  input  logic              jalr,
  input  logic [63:0]       imm,
  input  logic [63:0]       rs1_val,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] target,
  output logic              taken,
  output logic              target_misaligned
);

  logic [63:0] pc_wide;
  logic [63:0] seq_sum;
  logic [63:0] rel_sum;
  logic [63:0] jalr_sum;
  logic        cond_true;

  // Sums are formed at full 64-bit width and truncated, so they wrap mod 2^ADDR_W
  assign pc_wide  = 64'(pc);
  assign seq_sum  = pc_wide + 64'd4;
  assign rel_sum  = pc_wide + (imm << 1);
  assign jalr_sum = (rs1_val + imm) & JALR_LSB_MASK;

  always_comb begin
    cond_true = 1'b0;
    case (br_funct3)
      BEQ:     cond_true = zero;
      BNE:     cond_true = ~zero;
      BLT:     cond_true = lt;
      BGE:     cond_true = ~lt;
      BLTU:    cond_true = ltu;
      BGEU:    cond_true = ~ltu;
      default: cond_true = 1'b0;
    endcase
  end

  // JAL and branches share the pc-relative target; JALR overrides both
  assign pc_plus4          = seq_sum[ADDR_W-1:0];
  assign target            = jalr ? jalr_sum[ADDR_W-1:0] : rel_sum[ADDR_W-1:0];
  assign taken             = jalr | jal | (branch & cond_true);
  assign target_misaligned = taken & (target[1:0] != 2'b00);

  generate
    if (ADDR_W < 64) begin : g_trunc
      logic unused_hi;
      assign unused_hi = ^{seq_sum[63:ADDR_W], rel_sum[63:ADDR_W], jalr_sum[63:ADDR_W]};
    end
  endgenerate

endmodule

// File: rtl/pc_next_unit.sv
// Program-counter unit: holds the PC, issues fetch requests with a
// valid/ready handshake and traps on misaligned control-transfer targets.
module pc_next_unit
  import pc_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] TRAP_PC  = 'h80
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              fetch_ready,
  output logic              fetch_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  input  logic              branch,
  input  logic [2:0]        br_funct3,
  input  logic              zero,
  input  logic              lt,
  input  logic              ltu,
  input  logic              jal,
  input  logic              jalr,
  input  logic [63:0]       imm,
  input  logic [63:0]       rs1_val,
  input  logic              trap_clear,
  output logic              redirect,
  output logic              misaligned
);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] target;
  logic              taken;
  logic              target_misaligned;
  logic              advance;

  pc_target_gen #(.ADDR_W(ADDR_W)) u_target_gen (
    .pc                (pc),
    .branch            (branch),
    .br_funct3         (br_funct3),
    .zero              (zero),
    .lt                (lt),
    .ltu               (ltu),
    .jal               (jal),
    .jalr              (jalr),
    .imm               (imm),
    .rs1_val           (rs1_val),
    .pc_plus4          (pc_plus4),
    .target            (target),
    .taken             (taken),
    .target_misaligned (target_misaligned)
  );

  assign advance = (state == RUN) & fetch_ready & ~stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      BOOT:    state_next = RUN;
      RUN:     if (advance && target_misaligned) state_next = TRAP;
      TRAP:    if (trap_clear) state_next = RUN;
      default: state_next = BOOT;
    endcase
  end

  always_comb begin
    fetch_valid = (state == RUN);
    misaligned  = (state == TRAP);
  end

  // A misaligned transfer leaves pc untouched so the faulting instruction stays visible
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      redirect <= 1'b0;
    end else begin
      redirect <= advance & taken & ~target_misaligned;
      if (advance) begin
        if (!taken)                 pc <= pc_plus4;
        else if (!target_misaligned) pc <= target;
      end else if (state == TRAP && trap_clear) begin
        pc <= TRAP_PC;
      end
    end
  end

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit: a behavioural model checked every cycle
// plus hand-computed literal expectations along the scenario.
module tb_pc_next_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [7:0]  pc;
  logic [7:0]  pc_plus4;
  logic        branch;
  logic [2:0]  br_funct3;
  logic        zero;
  logic        lt;
  logic        ltu;
  logic        jal;
  logic        jalr;
  logic [63:0] imm;
  logic [63:0] rs1_val;
  logic        trap_clear;
  logic        redirect;
  logic        misaligned;

  int total = 0;
  int bad   = 0;

  pc_next_unit #(.ADDR_W(8), .RESET_PC(8'h00), .TRAP_PC(8'h80)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .fetch_ready (fetch_ready),
    .fetch_valid (fetch_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .branch      (branch),
    .br_funct3   (br_funct3),
    .zero        (zero),
    .lt          (lt),
    .ltu         (ltu),
    .jal         (jal),
    .jalr        (jalr),
    .imm         (imm),
    .rs1_val     (rs1_val),
    .trap_clear  (trap_clear),
    .redirect    (redirect),
    .misaligned  (misaligned)
  );

  always #5 clk = ~clk;

  // Model state: boot flag, trap flag, pc as a plain integer mod 256
  bit          m_booting;
  bit          m_trapped;
  int unsigned m_pc;
  bit          m_redirect;

  function automatic bit model_taken();
    if (jalr || jal) return 1'b1;
    if (!branch) return 1'b0;
    case (br_funct3)
      3'd0: return zero;
      3'd1: return !zero;
      3'd4: return lt;
      3'd5: return !lt;
      3'd6: return ltu;
      3'd7: return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int unsigned model_target();
    longint unsigned t;
    if (jalr) t = (rs1_val + imm) & ~64'd1;
    else      t = 64'(m_pc) + imm * 2;
    return int'(t % 256);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_booting  <= 1'b1;
      m_trapped  <= 1'b0;
      m_pc       <= 0;
      m_redirect <= 1'b0;
    end else if (m_booting) begin
      m_booting  <= 1'b0;
      m_redirect <= 1'b0;
    end else if (m_trapped) begin
      m_redirect <= 1'b0;
      if (trap_clear) begin
        m_trapped <= 1'b0;
        m_pc      <= 'h80;
      end
    end else if (fetch_ready && !stall) begin
      if (!model_taken()) begin
        m_pc       <= (m_pc + 4) % 256;
        m_redirect <= 1'b0;
      end else if (model_target() % 4 != 0) begin
        m_trapped  <= 1'b1;
        m_redirect <= 1'b0;
      end else begin
        m_pc       <= model_target();
        m_redirect <= 1'b1;
      end
    end else begin
      m_redirect <= 1'b0;
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    cmp("model.pc", int'(pc), int'(m_pc));
    cmp("model.pc_plus4", int'(pc_plus4), int'((m_pc + 4) % 256));
    cmp("model.fetch_valid", int'(fetch_valid), int'(!m_booting && !m_trapped));
    cmp("model.misaligned", int'(misaligned), int'(m_trapped));
    cmp("model.redirect", int'(redirect), int'(m_redirect));
  end

  task automatic applyStimulus(input bit br, input logic [2:0] f3, input bit z,
                               input bit l, input bit lu, input bit j, input bit jr,
                               input logic [63:0] im, input logic [63:0] rs1,
                               input bit tc, input bit st, input bit rdy);
    branch = br; br_funct3 = f3; zero = z; lt = l; ltu = lu;
    jal = j; jalr = jr; imm = im; rs1_val = rs1;
    trap_clear = tc; stall = st; fetch_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 3'd0, 0, 0, 0, 0, 0, 64'd0, 64'd0, 0, 0, 1);
  endtask

  task automatic checkOutput(input string name, input logic [7:0] exp_pc,
                             input bit exp_fv, input bit exp_mis, input bit exp_red);
    cmp({name, ".pc"}, int'(pc), int'(exp_pc));
    cmp({name, ".fetch_valid"}, int'(fetch_valid), int'(exp_fv));
    cmp({name, ".misaligned"}, int'(misaligned), int'(exp_mis));
    cmp({name, ".redirect"}, int'(redirect), int'(exp_red));
  endtask

  typedef struct {
    logic [2:0] f3;
    bit z;
    bit l;
    bit lu;
    bit exp_taken;
  } cond_vec_t;

  cond_vec_t conds[10] = '{
    '{3'd4, 0, 1, 0, 1}, '{3'd4, 0, 0, 0, 0}, '{3'd5, 0, 0, 0, 1},
    '{3'd5, 0, 1, 0, 0}, '{3'd6, 0, 0, 1, 1}, '{3'd7, 0, 0, 1, 0},
    '{3'd7, 0, 0, 0, 1}, '{3'd1, 1, 0, 0, 0}, '{3'd2, 1, 1, 1, 0},
    '{3'd3, 1, 1, 1, 0}
  };

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] exp_pc;
    rst_n = 1'b0;
    branch = 0; br_funct3 = 0; zero = 0; lt = 0; ltu = 0; jal = 0; jalr = 0;
    imm = 0; rs1_val = 0; trap_clear = 0; stall = 0; fetch_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 8'h00, 0, 0, 0);
    rst_n = 1'b1;
    #1;
    checkOutput("boot", 8'h00, 0, 0, 0);

    idle(); checkOutput("seq0", 8'h00, 1, 0, 0);
    idle(); checkOutput("seq1", 8'h04, 1, 0, 0);
    idle(); checkOutput("seq2", 8'h08, 1, 0, 0);
    idle(); checkOutput("seq3", 8'h0C, 1, 0, 0);
    idle(); checkOutput("seq4", 8'h10, 1, 0, 0);

    applyStimulus(1, 3'd0, 1, 0, 0, 0, 0, 64'd6, 64'd0, 0, 0, 1);
    checkOutput("beq_taken", 8'h1C, 1, 0, 1);
    idle(); checkOutput("redirect_once", 8'h20, 1, 0, 0);
    applyStimulus(0, 3'd0, 0, 0, 0, 1, 0, -64'sd8, 64'd0, 0, 0, 1);
    checkOutput("jal_back", 8'h10, 1, 0, 1);
    applyStimulus(1, 3'd0, 0, 0, 0, 0, 0, 64'd6, 64'd0, 0, 0, 1);
    checkOutput("beq_not_taken", 8'h14, 1, 0, 0);

    applyStimulus(0, 3'd0, 0, 0, 0, 0, 1, 64'd0, 64'hFC, 0, 0, 1);
    checkOutput("jalr_to_fc", 8'hFC, 1, 0, 1);
    idle(); checkOutput("wrap_seq", 8'h00, 1, 0, 0);
    idle(); checkOutput("after_wrap", 8'h04, 1, 0, 0);
    applyStimulus(1, 3'd1, 0, 0, 0, 0, 0, -64'sd2, 64'd0, 0, 0, 1);
    checkOutput("bne_wrap", 8'h00, 1, 0, 1);
    applyStimulus(0, 3'd0, 0, 0, 0, 1, 0, -64'sd2, 64'd0, 0, 0, 1);
    checkOutput("jal_wrap", 8'hFC, 1, 0, 1);

    applyStimulus(0, 3'd0, 0, 0, 0, 0, 1, 64'd3, 64'h41, 0, 0, 1);
    checkOutput("jalr_clear_lsb", 8'h44, 1, 0, 1);
    applyStimulus(0, 3'd0, 0, 0, 0, 0, 1, 64'd2, 64'h40, 0, 0, 1);
    checkOutput("jalr_misaligned", 8'h44, 0, 1, 0);
    idle(); checkOutput("trap_hold", 8'h44, 0, 1, 0);
    applyStimulus(0, 3'd0, 0, 0, 0, 0, 0, 64'd0, 64'd0, 1, 0, 1);
    checkOutput("trap_clear", 8'h80, 1, 0, 0);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 3'd0, 0, 0, 0, 1, 0, 64'd8, 64'd0, 0, 0, 0);
      checkOutput("not_ready_hold", 8'h80, 1, 0, 0);
    end
    applyStimulus(0, 3'd0, 0, 0, 0, 1, 0, 64'd8, 64'd0, 0, 1, 1);
    checkOutput("stall_hold", 8'h80, 1, 0, 0);
    idle(); checkOutput("release", 8'h84, 1, 0, 0);

    exp_pc = 8'h84;
    foreach (conds[i]) begin
      applyStimulus(1, conds[i].f3, conds[i].z, conds[i].l, conds[i].lu, 0, 0,
                    64'd4, 64'd0, 0, 0, 1);
      exp_pc = exp_pc + (conds[i].exp_taken ? 8'd8 : 8'd4);
      checkOutput("cond_table", exp_pc, 1, 0, conds[i].exp_taken);
    end

    applyStimulus(1, 3'd0, 1, 0, 0, 1, 1, 64'd0, 64'h20, 0, 0, 1);
    checkOutput("prio_jalr", 8'h20, 1, 0, 1);
    applyStimulus(1, 3'd0, 0, 0, 0, 1, 0, 64'd4, 64'd0, 0, 0, 1);
    checkOutput("prio_jal", 8'h28, 1, 0, 1);
    applyStimulus(0, 3'd0, 0, 0, 0, 0, 0, 64'd0, 64'd0, 1, 0, 1);
    checkOutput("clear_in_run", 8'h2C, 1, 0, 0);

    applyStimulus(0, 3'd0, 0, 0, 0, 0, 1, 64'd0, 64'd2, 0, 0, 1);
    checkOutput("trap_again", 8'h2C, 0, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_in_trap", 8'h00, 0, 0, 0);
    #1;
    rst_n = 1'b1;
    idle(); checkOutput("boot_after_reset", 8'h00, 1, 0, 0);
    idle(); checkOutput("run_after_reset", 8'h04, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
